// File: rtl/maquina_estados_tamagotchi.sv
// Pet state FSM: buttons and attribute levels drive the one-hot estado bus.
// Optional AUTO_DORMIR_EN: idle pet with low sono falls asleep unprompted.
module maquina_estados_tamagotchi #(
  parameter int unsigned DURACAO_ATIV = 83886080,
  parameter int unsigned LIMITE_ZERO  = 8388608,
  parameter int unsigned MAX_ATRIB    = 100,
  parameter int unsigned LIMIAR_SONO  = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_start,
  input  logic       btn_comer,
  input  logic       btn_dormir,
  input  logic       btn_aula,
  input  logic [7:0] fome,
  input  logic [7:0] felicidade,
  input  logic [7:0] sono,
  output logic [4:0] estado,
  output logic       evento_morte
);

  localparam int unsigned MAXC =
    (DURACAO_ATIV > LIMITE_ZERO) ? DURACAO_ATIV : LIMITE_ZERO;
  localparam int CW = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [CW-1:0] ATIV_FIM = CW'(DURACAO_ATIV - 1);
  localparam logic [CW-1:0] ZERO_FIM = CW'(LIMITE_ZERO - 1);
  localparam logic [CW-1:0] UM       = CW'(1);
  localparam logic [7:0]    MAX_A    = 8'(MAX_ATRIB);
  localparam logic [7:0]    LIM_S    = 8'(LIMIAR_SONO);

`ifdef AUTO_DORMIR_EN
  localparam bit AUTO_ON = 1'b1;
`else
  localparam bit AUTO_ON = 1'b0;
`endif

  typedef enum logic [4:0] {
    INTRO      = 5'b00000,
    IDLE       = 5'b00001,
    DORMINDO   = 5'b00010,
    COMENDO    = 5'b00100,
    DANDO_AULA = 5'b01000,
    MORTO      = 5'b10000
  } estado_t;

  estado_t st, st_n;

  logic [3:0] btn_raw, s1, s2, prev, press;
  logic [CW-1:0] acnt, acnt_n, zcnt, zcnt_n;
  logic p_start, p_comer, p_dormir, p_aula;
  logic zero_any, em_ativ, vivo, completo, morre;

  assign btn_raw  = {btn_aula, btn_dormir, btn_comer, btn_start};
  assign p_start  = press[0];
  assign p_comer  = press[1];
  assign p_dormir = press[2];
  assign p_aula   = press[3];
  assign estado   = st;

  // All-ones reset hides a button held through reset until it is re-pressed
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1    <= 4'hF;
      s2    <= 4'hF;
      prev  <= 4'hF;
      press <= 4'h0;
    end else begin
      s1    <= btn_raw;
      s2    <= s1;
      prev  <= s2;
      press <= s2 & ~prev;
    end
  end

  assign zero_any = (fome == 8'd0) || (felicidade == 8'd0)
                 || (sono == 8'd0);
  assign em_ativ  = (st == DORMINDO) || (st == COMENDO)
                 || (st == DANDO_AULA);
  assign vivo     = em_ativ || (st == IDLE);
  assign morre    = vivo && zero_any && (zcnt == ZERO_FIM);

  always_comb begin
    completo = 1'b0;
    case (st)
      COMENDO:    completo = (fome >= MAX_A);
      DORMINDO:   completo = (sono >= MAX_A);
      DANDO_AULA: completo = (felicidade >= MAX_A);
      default:    completo = 1'b0;
    endcase
  end

  always_comb begin
    st_n = st;
    if (morre) begin
      st_n = MORTO;
    end else begin
      case (st)
        INTRO: if (p_start) st_n = IDLE;
        IDLE: begin
          if (p_comer)                         st_n = COMENDO;
          else if (p_dormir)                   st_n = DORMINDO;
          else if (p_aula)                     st_n = DANDO_AULA;
          else if (AUTO_ON && (sono < LIM_S))  st_n = DORMINDO;
        end
        DORMINDO, COMENDO, DANDO_AULA:
          if (p_start || completo || (acnt == ATIV_FIM)) st_n = IDLE;
        MORTO: if (p_start) st_n = INTRO;
        default: st_n = INTRO;
      endcase
    end
  end

  always_comb begin
    acnt_n = '0;
    zcnt_n = '0;
    if (em_ativ && (st_n == st)) acnt_n = acnt + UM;
    if (vivo && zero_any && (st_n != MORTO))
      zcnt_n = (zcnt == '1) ? zcnt : zcnt + UM;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st           <= INTRO;
      evento_morte <= 1'b0;
      acnt         <= '0;
      zcnt         <= '0;
    end else begin
      st           <= st_n;
      evento_morte <= (st_n == MORTO) && (st != MORTO);
      acnt         <= acnt_n;
      zcnt         <= zcnt_n;
    end
  end

endmodule

// File: tb/tb_maquina_estados_tamagotchi.sv
// Bench for maquina_estados_tamagotchi: directed steps plus random traffic
// checked every cycle against a behavioural pet model.
module tb_maquina_estados_tamagotchi;

  localparam int DUR = 16;
  localparam int LZ  = 4;
  localparam int MAXA = 100;
  localparam int LIM = 20;

  localparam logic [4:0] S_INTRO = 5'b00000;
  localparam logic [4:0] S_IDLE  = 5'b00001;
  localparam logic [4:0] S_DORM  = 5'b00010;
  localparam logic [4:0] S_COM   = 5'b00100;
  localparam logic [4:0] S_AULA  = 5'b01000;
  localparam logic [4:0] S_MORTO = 5'b10000;

  logic clk = 1'b0;
  logic rst_n;
  logic btn_start, btn_comer, btn_dormir, btn_aula;
  logic [7:0] fome, felicidade, sono;
  logic [4:0] estado;
  logic evento_morte;

  int tests = 0;
  int fails = 0;

  logic [4:0] m_st;
  logic m_ev;
  int m_act, m_zr;
  logic [3:0] hist [4];

  always #5 clk = ~clk;

  maquina_estados_tamagotchi #(
    .DURACAO_ATIV(DUR),
    .LIMITE_ZERO(LZ),
    .MAX_ATRIB(MAXA),
    .LIMIAR_SONO(LIM)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn_start(btn_start),
    .btn_comer(btn_comer),
    .btn_dormir(btn_dormir),
    .btn_aula(btn_aula),
    .fome(fome),
    .felicidade(felicidade),
    .sono(sono),
    .estado(estado),
    .evento_morte(evento_morte)
  );

  // A press counts three edges after the edge that first samples the level
  task automatic model_edge();
    logic [3:0] pr;
    logic [3:0] b;
    logic [4:0] nx;
    bit az, ativ, alive, die, done;
    if (!rst_n) begin
      m_st = S_INTRO; m_ev = 1'b0; m_act = 0; m_zr = 0;
      for (int i = 0; i < 4; i++) hist[i] = 4'hF;
      return;
    end
    b = {btn_aula, btn_dormir, btn_comer, btn_start};
    for (int i = 0; i < 4; i++) begin
      pr[i] = hist[i][2] & ~hist[i][3];
      hist[i] = {hist[i][2:0], b[i]};
    end
    az    = (fome == 0) || (felicidade == 0) || (sono == 0);
    ativ  = (m_st == S_DORM) || (m_st == S_COM) || (m_st == S_AULA);
    alive = ativ || (m_st == S_IDLE);
    die   = alive && az && (m_zr + 1 >= LZ);
    done  = (m_st == S_COM  && int'(fome) >= MAXA)
         || (m_st == S_DORM && int'(sono) >= MAXA)
         || (m_st == S_AULA && int'(felicidade) >= MAXA);
    nx = m_st;
    if (die) nx = S_MORTO;
    else if (m_st == S_INTRO) begin
      if (pr[0]) nx = S_IDLE;
    end else if (m_st == S_IDLE) begin
      if (pr[1]) nx = S_COM;
      else if (pr[2]) nx = S_DORM;
      else if (pr[3]) nx = S_AULA;
`ifdef AUTO_DORMIR_EN
      else if (int'(sono) < LIM) nx = S_DORM;
`endif
    end else if (m_st == S_MORTO) begin
      if (pr[0]) nx = S_INTRO;
    end else if (ativ) begin
      if (pr[0] || done || (m_act + 1 >= DUR)) nx = S_IDLE;
    end else nx = S_INTRO;
    m_ev  = (nx == S_MORTO) && (m_st != S_MORTO);
    m_zr  = (alive && az && nx != S_MORTO) ? m_zr + 1 : 0;
    m_act = (ativ && nx == m_st) ? m_act + 1 : 0;
    m_st  = nx;
  endtask

  task automatic check(input string tag);
    tests++;
    assert (estado === m_st) else begin
      fails++;
      $error("FAIL %s: estado=%b expected %b", tag, estado, m_st);
    end
    tests++;
    assert (evento_morte === m_ev) else begin
      fails++;
      $error("FAIL %s: evento_morte=%b expected %b", tag, evento_morte, m_ev);
    end
  endtask

  task automatic expect_st(input logic [4:0] exp, input string tag);
    tests++;
    assert (estado === exp) else begin
      fails++;
      $error("FAIL %s: estado=%b expected %b", tag, estado, exp);
    end
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check(tag);
  endtask

  task automatic run(input int n, input string tag);
    for (int i = 0; i < n; i++) tick(tag);
  endtask

  task automatic set_btn(input logic [3:0] v);
    {btn_aula, btn_dormir, btn_comer, btn_start} = v;
  endtask

  task automatic press(input logic [3:0] v, input string tag);
    set_btn(v);
    tick(tag);
    set_btn(4'h0);
    run(2, tag);
  endtask

  function automatic logic [7:0] pick_attr();
    int r;
    r = $urandom_range(0, 19);
    if (r == 0) return 8'd0;
    if (r == 1) return 8'd100;
    if (r == 2) return 8'($urandom_range(101, 255));
    return 8'($urandom_range(1, 99));
  endfunction

  initial begin
    logic [3:0] b;
    rst_n = 1'b0;
    set_btn(4'b0001);
    fome = 8'd50; felicidade = 8'd50; sono = 8'd50;
    run(2, "reset");
    expect_st(S_INTRO, "reset_intro");

    rst_n = 1'b1;
    run(3, "held_start");
    expect_st(S_INTRO, "held_start_ignored");
    set_btn(4'h0);
    run(2, "release");
    btn_start = 1'b1;
    run(3, "start_lat");
    expect_st(S_INTRO, "start_lat_2");
    tick("start_lat");
    expect_st(S_IDLE, "start_lat_3");
    btn_start = 1'b0;

    press(4'b1010, "comer_aula");
    tick("comer_aula");
    expect_st(S_COM, "prio_comer");
    run(15, "comer_run");
    expect_st(S_COM, "comer_15");
    tick("comer_to");
    expect_st(S_IDLE, "comer_timeout");

    press(4'b0010, "comer2");
    tick("comer2");
    run(5, "comer2_run");
    fome = 8'd100;
    tick("comer_full");
    expect_st(S_IDLE, "comer_complete");
    fome = 8'd50;

    press(4'b0100, "dormir");
    tick("dormir");
    expect_st(S_DORM, "dormindo");
    run(4, "dormir_run");
    press(4'b0001, "cancel");
    tick("cancel");
    expect_st(S_IDLE, "cancel_idle");

    press(4'b0100, "dormir2");
    tick("dormir2");
    press(4'b0010, "comer_ign");
    run(3, "comer_ign");
    expect_st(S_DORM, "comer_ignored");
    run(10, "dormir2_to");
    expect_st(S_IDLE, "dormir_timeout");

    felicidade = 8'd0;
    run(3, "zero3");
    expect_st(S_IDLE, "zero3_alive");
    tick("death");
    expect_st(S_MORTO, "death");
    tick("death_after");
    felicidade = 8'd50;
    press(4'b0001, "revive");
    tick("revive");
    expect_st(S_INTRO, "revive_intro");
    press(4'b0001, "restart");
    tick("restart");

    felicidade = 8'd0;
    run(3, "zero_short");
    felicidade = 8'd1;
    run(3, "zero_clear");
    expect_st(S_IDLE, "zero_recover");
    felicidade = 8'd50;

    press(4'b1000, "aula");
    tick("aula");
    expect_st(S_AULA, "aula");
    run(12, "aula_run");
    fome = 8'd0;
    run(3, "aula_zero");
    expect_st(S_AULA, "aula_zero3");
    tick("death_vs_to");
    expect_st(S_MORTO, "death_wins");
    fome = 8'd50;
    press(4'b0001, "revive2");
    tick("revive2");
    press(4'b0001, "restart2");
    tick("restart2");

    press(4'b1000, "aula2");
    tick("aula2");
    run(5, "aula2_run");
    rst_n = 1'b0;
    tick("mid_reset");
    expect_st(S_INTRO, "mid_reset_intro");
    rst_n = 1'b1;
    run(2, "post_reset");
    press(4'b0001, "start3");
    tick("start3");
    press(4'b1000, "aula3");
    tick("aula3");
    run(15, "aula3_run");
    tick("aula3_to");
    expect_st(S_IDLE, "aula_full_after_reset");

`ifdef AUTO_DORMIR_EN
    sono = 8'd19;
    tick("auto");
    expect_st(S_DORM, "auto_dormir");
    sono = 8'd50;
    run(16, "auto_to");
    sono = 8'd20;
    run(3, "auto_thresh");
    expect_st(S_IDLE, "auto_threshold");
    sono = 8'd50;
`else
    sono = 8'd0;
    run(3, "no_auto");
    expect_st(S_IDLE, "no_auto_idle");
    tick("no_auto_death");
    expect_st(S_MORTO, "no_auto_death");
    sono = 8'd50;
    press(4'b0001, "revive3");
    tick("revive3");
`endif

    for (int n = 0; n < 800; n++) begin
      b = {btn_aula, btn_dormir, btn_comer, btn_start};
      for (int i = 0; i < 4; i++)
        if ($urandom_range(0, 5) == 0) b[i] = ~b[i];
      set_btn(b);
      if ($urandom_range(0, 4) == 0) fome = pick_attr();
      if ($urandom_range(0, 4) == 0) felicidade = pick_attr();
      if ($urandom_range(0, 4) == 0) sono = pick_attr();
      rst_n = ($urandom_range(0, 79) != 0);
      tick("random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
